// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The checksum byte is only present when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_LAST,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OVF     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   localparam int HDR_BYTES = 2;

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted payload bytes little-endian into 32-bit words and flags
// the byte that completes a word.
module loader_word_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_nxt,
   output logic        word_done
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   // Newest byte lands on top, so byte 0 ends up in bits 7:0 after four shifts.
   assign word_nxt  = {byte_in, shift_q};
   assign word_done = byte_en && (cnt_q == 2'd3);

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_en) begin
         shift_d = word_nxt[31:8];
         cnt_d   = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory, holds the CPU in reset
// until a complete image is resident. IMEM_LOADER_CSUM_EN adds the checksum byte.
//
// state | meaning
// IDLE  | no load since reset, CPU held
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte
// DATA  | receiving payload bytes, writing words
// LAST  | settle cycle after the final write
// CSUM  | waiting for the checksum byte
// DONE  | image resident, CPU released
// ERR   | load failed, err_code holds the cause
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int LEN_W = 8 * HDR_BYTES;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LEN_W:0]   MAX_WORDS = (LEN_W + 1)'(1 << ADDR_W);

   state_e              state_q, state_d;
   logic [7:0]          len_lo_q, len_lo_d;
   logic [ADDR_W:0]     nwords_q, nwords_d;
   logic [ADDR_W:0]     widx_q, widx_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic                accept;
   logic                load_go;
   logic [LEN_W-1:0]    len_full;
   logic [31:0]         word_nxt;
   logic                word_done;
   logic                waiting;

   assign rx_ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign waiting  = rx_ready;
   assign accept   = rx_valid && rx_ready;
   assign load_go  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
   assign len_full = {rx_data, len_lo_q};

   loader_word_pack u_pack (
      .clk       (clk),
      .rst       (rst),
      .clr       (load_go),
      .byte_en   (accept && (state_q == ST_DATA)),
      .byte_in   (rx_data),
      .word_nxt  (word_nxt),
      .word_done (word_done)
   );

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      nwords_d     = nwords_q;
      widx_d       = widx_q;
      tmo_d        = tmo_q;
      err_code_d   = err_code_q;
      imem_we_d    = 1'b0;
      imem_waddr_d = imem_waddr_q;
      imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d       = csum_q;
`endif

      if (waiting) begin
         if (accept)            tmo_d = TMO_LOAD;
         else if (tmo_q != '0)  tmo_d = tmo_q - 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_LEN0;
               widx_d     = '0;
               tmo_d      = TMO_LOAD;
               err_code_d = ERR_NONE;
`ifdef IMEM_LOADER_CSUM_EN
               csum_d     = '0;
`endif
            end
         end
         ST_LEN0: begin
            if (accept) begin
               len_lo_d = rx_data;
               state_d  = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (accept) begin
               if ({1'b0, len_full} > MAX_WORDS) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_OVF;
               end else if (len_full == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  nwords_d = len_full[ADDR_W:0];
                  state_d  = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (word_done) begin
                  imem_we_d    = 1'b1;
                  imem_waddr_d = widx_q[ADDR_W-1:0];
                  imem_wdata_d = word_nxt;
                  widx_d       = widx_q + 1'b1;
                  if (widx_q + 1'b1 == nwords_q) state_d = ST_LAST;
               end
            end
         end
         ST_LAST: begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
         end
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            if (accept) begin
               if (rx_data == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_CSUM;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // A stall in any byte-waiting state aborts the load.
      if (waiting && !accept && (tmo_q == '0)) begin
         state_d    = ST_ERR;
         err_code_d = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_lo_q     <= '0;
         nwords_q     <= '0;
         widx_q       <= '0;
         tmo_q        <= TMO_LOAD;
         err_code_q   <= ERR_NONE;
         imem_we_q    <= 1'b0;
         imem_waddr_q <= '0;
         imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         nwords_q     <= nwords_d;
         widx_q       <= widx_d;
         tmo_q        <= tmo_d;
         err_code_q   <= err_code_d;
         imem_we_q    <= imem_we_d;
         imem_waddr_q <= imem_waddr_d;
         imem_wdata_q <= imem_wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_waddr = imem_waddr_q;
   assign imem_wdata = imem_wdata_q;
   assign err_code   = err_code_q;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERR);
   assign cpu_rst    = (state_q != ST_DONE);
   assign busy       = rx_ready || (state_q == ST_LAST);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=8, TIMEOUT_CYCLES=16);
// checksum scenarios follow IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst, start, rx_valid, rx_ready;
   logic [7:0]  rx_data;
   logic        imem_we;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst, busy, done, error;
   logic [1:0]  err_code;

   int checks   = 0;
   int failures = 0;

   // Payload XOR: 13^00^08^20^05^00^09^20 = 0x17
   localparam logic [7:0] CSUM_GOOD = 8'h17;
   localparam logic [7:0] CSUM_BAD  = 8'h27;

   imem_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Memory-side view: every write the memory would capture, in order.
   int          wr_total = 0;
   logic [7:0]  wlog_addr [0:63];
   logic [31:0] wlog_data [0:63];
   always @(posedge clk) begin
      if (imem_we === 1'b1 && wr_total < 64) begin
         wlog_addr[wr_total] = imem_waddr;
         wlog_data[wr_total] = imem_wdata;
         wr_total++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL send_byte_wait: rx_ready got %b want 1 within 50 cycles", rx_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_payload(input int gap, input int nbytes);
      logic [7:0] pl [8];
      pl = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h05, 8'h00, 8'h09, 8'h20};
      for (int i = 0; i < nbytes; i++) begin
         repeat (gap) @(negedge clk);
         send_byte(pl[i]);
      end
   endtask

   task automatic test_reset();
      start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rx_ready, imem_we, imem_waddr, imem_wdata} !== {1'b0, 1'b0, 8'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_mem_side: got rdy=%b we=%b a=%h d=%h want 0 0 00 00000000",
                  rx_ready, imem_we, imem_waddr, imem_wdata);
      end
      checks++;
      if ({cpu_rst, busy, done, error, err_code} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_status: got cpu_rst=%b busy=%b done=%b error=%b code=%0d want 1 0 0 0 0",
                  cpu_rst, busy, done, error, err_code);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load(input int gap, input string tag);
      int base;
      base = wr_total;
      pulse_start();
      checks++;
      if ({busy, cpu_rst, done, rx_ready} !== 4'b1101) begin
         failures++;
         $display("FAIL %s_len0: got busy=%b cpu_rst=%b done=%b rdy=%b want 1 1 0 1",
                  tag, busy, cpu_rst, done, rx_ready);
      end
      send_byte(8'h02);
      repeat (gap) @(negedge clk);
      send_byte(8'h00);
      send_payload(gap, 8);
      checks++;
      if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'd1, 32'h20090005}) begin
         failures++;
         $display("FAIL %s_last_strobe: got we=%b a=%h d=%h want 1 01 20090005",
                  tag, imem_we, imem_waddr, imem_wdata);
      end
      checks++;
      if (cpu_rst !== 1'b1) begin
         failures++;
         $display("FAIL %s_hold_during_write: cpu_rst got %b want 1", tag, cpu_rst);
      end
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(CSUM_GOOD);
`else
      @(negedge clk);
`endif
      checks++;
      if ({done, error, cpu_rst, busy} !== 4'b1000) begin
         failures++;
         $display("FAIL %s_release: got done=%b error=%b cpu_rst=%b busy=%b want 1 0 0 0",
                  tag, done, error, cpu_rst, busy);
      end
      checks++;
      if (wr_total - base !== 2) begin
         failures++;
         $display("FAIL %s_write_count: got %0d want 2", tag, wr_total - base);
      end
      checks++;
      if ({wlog_addr[base], wlog_data[base]} !== {8'd0, 32'h20080013}) begin
         failures++;
         $display("FAIL %s_write0: got a=%h d=%h want 00 20080013", tag, wlog_addr[base], wlog_data[base]);
      end
      checks++;
      if ({wlog_addr[base+1], wlog_data[base+1]} !== {8'd1, 32'h20090005}) begin
         failures++;
         $display("FAIL %s_write1: got a=%h d=%h want 01 20090005", tag, wlog_addr[base+1], wlog_data[base+1]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, cpu_rst} !== 2'b10) begin
         failures++;
         $display("FAIL %s_done_sticky: got done=%b cpu_rst=%b want 1 0", tag, done, cpu_rst);
      end
   endtask

`ifdef IMEM_LOADER_CSUM_EN
   task automatic test_csum_bad();
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_payload(0, 8);
      send_byte(CSUM_BAD);
      checks++;
      if ({error, err_code, done, cpu_rst} !== {1'b1, 2'd3, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL csum_bad: got error=%b code=%0d done=%b cpu_rst=%b want 1 3 0 1",
                  error, err_code, done, cpu_rst);
      end
   endtask
`endif

   task automatic test_overflow();
      int base;
      base = wr_total;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);
      checks++;
      if ({error, err_code, busy, cpu_rst, rx_ready} !== {1'b1, 2'd1, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL overflow_err: got error=%b code=%0d busy=%b cpu_rst=%b rdy=%b want 1 1 0 1 0",
                  error, err_code, busy, cpu_rst, rx_ready);
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({error, err_code} !== {1'b1, 2'd1} || wr_total - base !== 0) begin
         failures++;
         $display("FAIL overflow_sticky: got error=%b code=%0d writes=%0d want 1 1 0",
                  error, err_code, wr_total - base);
      end
   endtask

   task automatic test_timeout();
      int base;
      int n;
      base = wr_total;
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_payload(0, 5);
      n = 0;
      while (error !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 16) begin
         failures++;
         $display("FAIL timeout_latency: error after %0d cycles want 16", n);
      end
      checks++;
      if ({error, err_code, cpu_rst} !== {1'b1, 2'd2, 1'b1}) begin
         failures++;
         $display("FAIL timeout_code: got error=%b code=%0d cpu_rst=%b want 1 2 1", error, err_code, cpu_rst);
      end
      checks++;
      if (wr_total - base !== 1 || {wlog_addr[base], wlog_data[base]} !== {8'd0, 32'h20080013}) begin
         failures++;
         $display("FAIL timeout_kept_word: got writes=%0d a=%h d=%h want 1 00 20080013",
                  wr_total - base, wlog_addr[base], wlog_data[base]);
      end
      pulse_start();
      checks++;
      if ({rx_ready, busy, error, err_code} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
         failures++;
         $display("FAIL timeout_restart: got rdy=%b busy=%b error=%b code=%0d want 1 1 0 0",
                  rx_ready, busy, error, err_code);
      end
      // Restart is from a clean LEN0: abandon it via reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_len();
      int base;
      base = wr_total;
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
      checks++;
      if ({rx_ready, done} !== 2'b10) begin
         failures++;
         $display("FAIL zero_len_csum_wait: got rdy=%b done=%b want 1 0", rx_ready, done);
      end
      send_byte(8'h00);
`endif
      checks++;
      if ({done, cpu_rst, error} !== 3'b100 || wr_total - base !== 0) begin
         failures++;
         $display("FAIL zero_len_done: got done=%b cpu_rst=%b error=%b writes=%0d want 1 0 0 0",
                  done, cpu_rst, error, wr_total - base);
      end
   endtask

   task automatic test_rst_mid();
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_payload(0, 6);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, busy, done, error, err_code}
          !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         failures++;
         $display("FAIL rst_mid: got rdy=%b we=%b a=%h d=%h cpu_rst=%b busy=%b done=%b error=%b code=%0d want idle/reset values",
                  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, busy, done, error, err_code);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_load(0, "b2b");
      test_load(3, "gap");
`ifdef IMEM_LOADER_CSUM_EN
      test_csum_bad();
`endif
      test_overflow();
      test_timeout();
      test_zero_len();
      test_rst_mid();
      test_load(0, "after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
